// File: rtl/spi_pkg.sv
// Shared SPI definitions: opcodes and master state encoding.
// Imported by both the SPI master and the slave.
package spi_pkg;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int unsigned CMD_BITS = 10;
  localparam int unsigned RD_BITS  = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_TURN,
    S_READ,
    S_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_sync2.sv
// Two-flop synchronizer for the MISO line.
// Only instantiated when SPI_MASTER_MISO_SYNC_EN is defined.
module spi_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops bring MISO into the clk domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spi_master.sv
// SPI master: 10-bit command out, optional 8-bit read back.
// Define SPI_MASTER_MISO_SYNC_EN to synchronize MISO (adds 2 turn cycles).
module spi_master
  import spi_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] frame,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int unsigned TURN_LEN = TURN_CYCLES + 2;
`else
  localparam int unsigned TURN_LEN = TURN_CYCLES;
`endif

  spi_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [9:0] cmd_q, cmd_d;
  logic [1:0] op_q, op_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       done_q, done_d;
  logic       rd_valid_q, rd_valid_d;
  logic       miso_s;

`ifdef SPI_MASTER_MISO_SYNC_EN
  spi_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (MISO),
    .q     (miso_s)
  );
`else
  assign miso_s = MISO;
`endif

  // State register and datapath flops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      op_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      op_q       <= op_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Next-state logic; done/rd_valid are set on the edge into GAP
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    op_d       = op_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d   = frame;
          op_d    = frame[9:8];
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        cmd_d = {cmd_q[8:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(CMD_BITS - 1)) begin
          cnt_d = '0;
          if (op_q == OP_RD_DATA) begin
            state_d = (TURN_LEN == 0) ? S_READ : S_TURN;
          end else begin
            state_d = S_GAP;
            done_d  = 1'b1;
          end
        end
      end
      S_TURN: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(TURN_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        rx_d  = {rx_q[6:0], miso_s};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(RD_BITS - 1)) begin
          cnt_d      = '0;
          rd_data_d  = {rx_q[6:0], miso_s};
          state_d    = S_GAP;
          done_d     = 1'b1;
          rd_valid_d = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(GAP_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign SS_n     = !(state_q == S_CMD ||
                      state_q == S_TURN ||
                      state_q == S_READ);
  assign MOSI     = (state_q == S_CMD) & cmd_q[9];
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a simple MISO slave model.
// Honors SPI_MASTER_MISO_SYNC_EN for the expected SS_n low time.
`timescale 1ns/1ps
module tb_spi_master;

  localparam int TC = 2;
  localparam int GC = 2;
`ifdef SPI_MASTER_MISO_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [9:0] frame;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  spi_master #(
    .TURN_CYCLES (TC),
    .GAP_CYCLES  (GC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .frame    (frame),
    .busy     (busy),
    .done     (done),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         lo_cnt;
  int         done_cnt;
  int         rdv_cnt;
  int         coin_bad;
  int         mosi_bad;
  logic [9:0] mosi_seq;
  logic [7:0] slv_pat;
  int         sl_idx;
  int         sl_j;

  // Bus monitor
  always @(negedge clk) begin
    if (!SS_n) begin
      if (lo_cnt < 10) mosi_seq = {mosi_seq[8:0], MOSI};
      lo_cnt++;
    end else if (MOSI !== 1'b0) begin
      mosi_bad++;
    end
    if (done) done_cnt++;
    if (rd_valid) rdv_cnt++;
    if (rd_valid && !done) coin_bad++;
  end

  // Slave: drives read bits after 10 command + TC turn cycles
  always @(negedge clk) begin
    if (!SS_n) begin
      sl_j = sl_idx - 10 - TC;
      if (sl_j >= 0 && sl_j < 8) MISO = slv_pat[7 - sl_j];
      else MISO = 1'b0;
      sl_idx++;
    end else begin
      sl_idx = 0;
      MISO   = 1'b0;
    end
  end

  task automatic clear();
    lo_cnt   = 0;
    done_cnt = 0;
    rdv_cnt  = 0;
    coin_bad = 0;
    mosi_bad = 0;
    mosi_seq = '0;
  endtask

  task automatic send(input logic [9:0] f);
    @(negedge clk);
    frame = f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_to"}, 32'(t < 200), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t;
    int hi;
    reset   = 1'b1;
    start   = 1'b0;
    frame   = '0;
    MISO    = 1'b0;
    slv_pat = 8'hCC;
    sl_idx  = 0;
    sl_j    = 0;
    clear();
    repeat (3) @(negedge clk);
    check("rst_ssn", 32'(SS_n), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdv", 32'(rd_valid), 0);
    check("rst_rdd", 32'(rd_data), 0);

    // wr_addr accepted on the first edge after reset release
    @(negedge clk);
    reset = 1'b0;
    frame = 10'b00_0000_0001;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_acc", 32'(busy), 1);
    wait_idle("wa");
    check("wa_mosi", 32'(mosi_seq), 32'h001);
    check("wa_low", lo_cnt, 10);
    check("wa_done", done_cnt, 1);
    check("wa_rdv", rdv_cnt, 0);
    check("wa_ss_mosi", mosi_bad, 0);

    // rd_data read of 0xCC
    clear();
    send(10'b11_0000_0011);
    wait_idle("rd");
    check("rd_data", 32'(rd_data), 32'hCC);
    check("rd_rdv", rdv_cnt, 1);
    check("rd_done", done_cnt, 1);
    check("rd_coin", coin_bad, 0);
    check("rd_low", lo_cnt, 20 + EXTRA);
    check("rd_mosi", 32'(mosi_seq), 32'h303);

    // wr_data with a start pulse during CMD
    clear();
    send(10'h103);
    repeat (3) @(negedge clk);
    frame = 10'h2FF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle("wd");
    repeat (5) @(negedge clk);
    check("wd_done", done_cnt, 1);
    check("wd_low", lo_cnt, 10);
    check("wd_mosi", 32'(mosi_seq), 32'h103);
    check("wd_hold", 32'(rd_data), 32'hCC);
    check("wd_rdv", rdv_cnt, 0);

    // reset during CMD bit 5
    clear();
    send(10'h0A5);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("ab_ssn", 32'(SS_n), 1);
    check("ab_mosi", 32'(MOSI), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_rdd", 32'(rd_data), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("ab_done", done_cnt, 0);
    clear();
    send(10'h2A5);
    wait_idle("ab2");
    check("ab2_mosi", 32'(mosi_seq), 32'h2A5);
    check("ab2_low", lo_cnt, 10);
    check("ab2_done", done_cnt, 1);

    // start held through done: SS_n high GAP + 1 idle cycle
    clear();
    @(negedge clk);
    frame = 10'h155;
    start = 1'b1;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("bb_done_to", 32'(t < 100), 1);
    hi = 0;
    while (SS_n && hi < 50) begin
      hi++;
      @(negedge clk);
    end
    start = 1'b0;
    check("bb_gap", hi, GC + 1);
    wait_idle("bb");
    check("bb_done", done_cnt, 2);
    check("bb_mosi", 32'(mosi_seq), 32'h155);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter TURN_CYCLES, default 2, meaning clk cycles between the last command bit and the first MISO sample (range 0..15).
REQ-002 SHALL have parameter GAP_CYCLES, default 2, meaning minimum SS_n-high cycles between frames (range 1..15).
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to send frame; sampled only in IDLE.
REQ-006 SHALL have port frame  input  10  command: [9:8] opcode (00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data), [7:0] payload.
REQ-007 SHALL have port busy  output  1  high from the cycle after start acceptance until return to IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse at frame completion.
REQ-009 SHALL have port rd_data  output  8  byte received on MISO for an opcode-11 frame.
REQ-010 SHALL have port rd_valid  output  1  one-cycle pulse, coincident with done, only for opcode 11.
REQ-011 SHALL have port SS_n  output  1  active-low slave select.
REQ-012 SHALL have port MOSI  output  1  serial command out, MSB first.
REQ-013 SHALL have port MISO  input  1  serial read data in, MSB first.

Function
REQ-014 SHALL implement states IDLE, CMD, TURN, READ, GAP.
REQ-015 SHALL, in IDLE with start=1, latch frame and enter CMD on the next edge; start while busy SHALL be ignored.
REQ-016 SHALL, in CMD, hold SS_n=0 and drive MOSI=frame[9-k] during the k-th CMD cycle, k=0..9, i.e. exactly 10 cycles.
REQ-017 SHALL, after CMD with opcode != 11, enter GAP directly.
REQ-018 SHALL, after CMD with opcode 11, enter TURN for TURN_CYCLES cycles (skipped if 0) with SS_n=0, MOSI=0.
REQ-019 SHALL, in READ, hold SS_n=0 for 8 cycles, shifting MISO into a shift register at each rising edge, MSB first.
REQ-020 SHALL, on READ exit, load rd_data from the shift register and pulse rd_valid and done in the first GAP cycle.
REQ-021 SHALL pulse done in the first GAP cycle for every frame type.
REQ-022 SHALL hold SS_n=1, MOSI=0 in GAP for GAP_CYCLES cycles, then return to IDLE; busy SHALL deassert upon entering IDLE.
REQ-023 SHALL hold rd_data unchanged except at REQ-020 loads.
REQ-024 SHALL drive MOSI=0 whenever SS_n=1.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-frame, immediately force SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0x00, state IDLE, with no done pulse for the aborted frame.
REQ-026 SHALL accept start on the first rising edge after reset deassertion.

Configuration
REQ-027 SHALL support macro SPI_MASTER_MISO_SYNC_EN: when defined, MISO passes through a two-flop synchronizer and the effective TURN duration becomes TURN_CYCLES+2; when undefined, MISO is sampled directly with TURN_CYCLES as specified.

Structure
REQ-028 SHALL place opcode constants (OP_WR_ADDR, OP_WR_DATA, OP_RD_ADDR, OP_RD_DATA) and the state encoding in shared package spi_pkg, also used by the slave.
REQ-029 SHALL instantiate the MISO synchronizer as sub-module spi_sync2, present only under SPI_MASTER_MISO_SYNC_EN.

Verification
REQ-030 SHALL verify wr_addr: frame=10'b00_0000_0001 -> MOSI sequence 0000000001, SS_n low exactly 10 cycles, one done pulse, no rd_valid.
REQ-031 SHALL verify rd_data: frame=10'b11_0000_0011, slave model drives 0xCC after turnaround -> rd_data=0xCC, rd_valid and done coincident, SS_n low 20 cycles (defaults).
REQ-032 SHALL verify start pulsed during CMD of a wr_data frame 0x103 is ignored: one frame, one done.
REQ-033 SHALL verify reset asserted at CMD bit 5 -> SS_n=1 in the same time step, no done, next start yields a complete correct frame.
REQ-034 SHALL verify start held high at done -> next SS_n falling edge no earlier than GAP_CYCLES cycles after SS_n rises.
REQ-035 SHALL verify, with SPI_MASTER_MISO_SYNC_EN defined, REQ-031 still yields rd_data=0xCC with SS_n low 22 cycles.
